// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch/decode/execute sequencer: state codes, opcodes and the vector entry PC.
package fetch_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_VEC_WAIT = 3'd4;
    localparam logic [2:0] ST_HALT     = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        EXEC     = ST_EXEC,
        VEC_WAIT = ST_VEC_WAIT,
        HALT     = ST_HALT
    } seq_state_t;

    localparam logic [3:0]  OPC_BRANCH = 4'hC;
    localparam logic [3:0]  OPC_VEC    = 4'hE;
    localparam logic [3:0]  OPC_HALT   = 4'hF;
    localparam logic [15:0] VEC_ENTRY  = 16'hFFF0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the sequencer's memory, PC-control and execute/vector handshake signals.
interface fetch_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic              exec_valid;
    logic              vec_start;
    logic              vec_done;
    logic              pc_enable;
    logic              pc_jump;
    logic              pc_vdone;
    logic              halted;
    logic              fetch_err;

    modport master (
        input  start, imem_ack, imem_rdata, vec_done,
        output imem_req, instr, exec_valid, vec_start,
               pc_enable, pc_jump, pc_vdone, halted, fetch_err
    );

    modport slave (
        output start, imem_ack, imem_rdata, vec_done,
        input  imem_req, instr, exec_valid, vec_start,
               pc_enable, pc_jump, pc_vdone, halted, fetch_err
    );
endinterface

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts unacked FETCH cycles; flags expiry and holds a sticky error (FETCH_TIMEOUT_EN only).
// Latency: expire is combinational in the cycle the count would reach TIMEOUT_CYCLES; err registers one edge later.
// Backpressure: none; it only observes the fetch handshake.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic expire,
    output logic err
);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    assign expire = active && !ack && (count == LAST);

    // Count is held at zero outside FETCH, so each fetch starts from a clean slate.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 8'd0;
            err   <= 1'b0;
        end else begin
            if (active && !ack) count <= count + 8'd1;
            else                count <= 8'd0;
            if (expire) err <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller driving PC enable/jump/vdone; FETCH_TIMEOUT_EN adds a fetch watchdog.
// Latency: ALU/branch instruction 3 cycles with zero-wait fetch; vector op 4 cycles plus vec_done wait.
// Backpressure: holds imem_req until imem_ack; parks in VEC_WAIT until vec_done.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_MAX       = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clock,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    if (ADDR_MAX < 12 || DATA_W < 12 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("fetch_sequencer: unsupported parameter combination");
    end

    seq_state_t        state;
    logic [DATA_W-1:0] instr_q;
    logic              imem_req_q;
    logic              exec_valid_q;
    logic              vec_start_q;
    logic              pc_en_q;
    logic              pc_jump_q;
    logic              halted_q;
    logic              wd_expire;
    logic              vec_finish;
    logic [3:0]        opc;

    assign opc        = instr_q[DATA_W-1 -: 4];
    // vec_done is honoured in the very cycle it is seen, including the first VEC_WAIT cycle.
    assign vec_finish = (state == VEC_WAIT) && bus.vec_done;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .active (state == FETCH),
        .ack    (bus.imem_ack),
        .expire (wd_expire),
        .err    (bus.fetch_err)
    );
`else
    assign wd_expire     = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            instr_q      <= '0;
            imem_req_q   <= 1'b0;
            exec_valid_q <= 1'b0;
            vec_start_q  <= 1'b0;
            pc_en_q      <= 1'b0;
            pc_jump_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            exec_valid_q <= 1'b0;
            vec_start_q  <= 1'b0;
            pc_en_q      <= 1'b0;
            pc_jump_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q    <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state      <= DECODE;
                    end else if (wd_expire) begin
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state      <= HALT;
                    end
                end
                // EXEC pulses are set here so they appear registered in the EXEC cycle.
                DECODE: begin
                    if (opc == OPC_HALT) begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else begin
                        state <= EXEC;
                        if (opc == OPC_BRANCH) begin
                            pc_en_q   <= 1'b1;
                            pc_jump_q <= 1'b1;
                        end else if (opc == OPC_VEC) begin
                            vec_start_q <= 1'b1;
                        end else begin
                            exec_valid_q <= 1'b1;
                            pc_en_q      <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (opc == OPC_VEC) begin
                        state <= VEC_WAIT;
                    end else begin
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                VEC_WAIT: begin
                    if (bus.vec_done) begin
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr      = instr_q;
    assign bus.imem_req   = imem_req_q;
    assign bus.exec_valid = exec_valid_q;
    assign bus.vec_start  = vec_start_q;
    assign bus.pc_enable  = pc_en_q | vec_finish;
    assign bus.pc_jump    = pc_jump_q;
    assign bus.pc_vdone   = vec_finish;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small Prog_Counter stand-in; define FETCH_TIMEOUT_EN to cover the watchdog.
module tb_fetch_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] pc;
    int   cnt;

    fetch_sequencer_if #(.DATA_W(16)) bus ();

    fetch_sequencer #(
        .ADDR_MAX       (16),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Prog_Counter stand-in: +1, relative jump by sext(instr[11:0]), or vector entry.
    always @(posedge clock) begin
        if (reset) pc <= 16'h0000;
        else if (bus.pc_enable) begin
            if (bus.pc_vdone)     pc <= 16'hFFF0;
            else if (bus.pc_jump) pc <= pc + {{4{bus.instr[11]}}, bus.instr[11:0]};
            else                  pc <= pc + 16'h0001;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_outs"}, {bus.imem_req, bus.exec_valid, bus.vec_start, bus.pc_enable,
                             bus.pc_jump, bus.pc_vdone, bus.halted, bus.fetch_err}, 32'h0);
    endtask

    // From FETCH: ack with word w, then DECODE, landing in EXEC.
    task automatic fetch_to_exec(input logic [15:0] w);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        step();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.vec_done   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk_quiet("reset_idle");
        chk("reset_instr", bus.instr, 32'h0);

        // ALU op, zero-wait fetch
        bus.start      = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1234;
        step();
        bus.start = 1'b0;
        chk("alu_req_c1", bus.imem_req, 32'h1);
        step();
        bus.imem_ack = 1'b0;
        chk("alu_instr", bus.instr, 32'h1234);
        chk("alu_decode_quiet", {bus.imem_req, bus.pc_enable, bus.exec_valid}, 32'h0);
        step();
        chk("alu_exec_c3", {bus.exec_valid, bus.pc_enable, bus.pc_jump}, 32'b110);
        step();
        chk("alu_pc", pc, 32'h1);
        chk("alu_back_fetch", {bus.imem_req, bus.exec_valid, bus.pc_enable}, 32'b100);

        for (int i = 0; i < 4; i++) begin
            fetch_to_exec(16'h1000);
            step();
        end
        chk("pc_at_5", pc, 32'h5);

        // branch -2
        fetch_to_exec(16'hCFFE);
        chk("br_exec", {bus.pc_enable, bus.pc_jump, bus.exec_valid, bus.pc_vdone}, 32'b1100);
        step();
        chk("br_pc", pc, 32'h3);
        chk("br_after", {bus.pc_enable, bus.pc_jump}, 32'h0);

        // vector op, vec_done after 10 cycles
        cnt = 0;
        fetch_to_exec(16'hE000);
        chk("vec_exec", {bus.vec_start, bus.pc_enable}, 32'b10);
        if (bus.vec_start) cnt++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.vec_start) cnt++;
            if (bus.pc_enable) cnt += 100;
        end
        bus.vec_done = 1'b1;
        #1;
        chk("vec_done_outs", {bus.pc_enable, bus.pc_vdone, bus.pc_jump}, 32'b110);
        step();
        bus.vec_done = 1'b0;
        chk("vec_pulse_count", cnt, 32'd1);
        chk("vec_pc", pc, 32'hFFF0);
        chk("vec_after", {bus.pc_enable, bus.imem_req}, 32'b01);

        // vec_done already high when VEC_WAIT is entered
        bus.vec_done = 1'b1;
        fetch_to_exec(16'hE123);
        chk("vec2_exec_noen", bus.pc_enable, 32'h0);
        step();
        chk("vec2_immediate", {bus.pc_enable, bus.pc_vdone}, 32'b11);
        step();
        bus.vec_done = 1'b0;
        chk("vec2_refetch", bus.imem_req, 32'h1);

        // halt
        fetch_to_exec(16'hF000);
        chk("halt_set", bus.halted, 32'h1);
        bus.start    = 1'b1;
        bus.imem_ack = 1'b1;
        step();
        step();
        step();
        bus.start    = 1'b0;
        bus.imem_ack = 1'b0;
        chk("halt_sticky", {bus.halted, bus.imem_req, bus.pc_enable, bus.exec_valid}, 32'b1000);
        chk("halt_pc", pc, 32'hFFF0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_quiet("halt_reset");

        // reset in VEC_WAIT with vec_done low
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        fetch_to_exec(16'hE000);
        step();
        step();
        reset = 1'b1;
        step();
        chk_quiet("vw_reset");
        chk("vw_reset_instr", bus.instr, 32'h0);
        chk("vw_reset_pc", pc, 32'h0);
        reset = 1'b0;
        step();

`ifdef FETCH_TIMEOUT_EN
        cnt = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req) cnt++;
            step();
        end
        chk("wd_req_cycles", cnt, 32'd4);
        chk("wd_err_halt", {bus.fetch_err, bus.halted, bus.imem_req}, 32'b110);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("wd_err_cleared", bus.fetch_err, 32'h0);
`else
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 300; i++) step();
        chk("nowd_still_fetching", {bus.imem_req, bus.fetch_err, bus.halted}, 32'b100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
